// File: rtl/serial_tx_if.sv
// Parallel-load / serial-out link bundle between a frame source and serial_tx.
// Handshake: load is sampled on a rising clock edge only while ready=1; busy and ready are complementary.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              load;
  logic [DATA_W-1:0] data_in;
  logic              tx;
  logic              ready;
  logic              busy;
  logic              done;
  logic [1:0]        state;

  modport master (
    output load, data_in,
    input  tx, ready, busy, done, state
  );

  modport slave (
    input  load, data_in,
    output tx, ready, busy, done, state
  );
endinterface

// File: rtl/serial_tx.sv
// Start/data/stop frame serializer: one start bit (0), DATA_W data bits, one stop bit (1),
// each held CLKS_PER_BIT clocks; every line output comes straight from a flop.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int LSB_FIRST    = 1
) (
  input  logic        clock,
  input  logic        resetn,
  serial_tx_if.slave  bus,
  output logic        LED0,
  output logic        LED9
);
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DIV_W-1:0]  div_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              slot_end;
  logic              cur_bit;
  logic              next_bit;

  assign slot_end = (div_q == DIV_W'(CLKS_PER_BIT - 1));
  assign shreg_d  = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
  assign cur_bit  = (LSB_FIRST != 0) ? shreg_q[0] : shreg_q[DATA_W-1];
  // tx is registered, so the bit for the next slot is taken from the already-shifted word
  assign next_bit = (LSB_FIRST != 0) ? shreg_d[0] : shreg_d[DATA_W-1];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.load) begin
            shreg_q   <= bus.data_in;
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            state_q   <= START;
          end
        end
        START: begin
          if (slot_end) begin
            div_q     <= '0;
            bit_cnt_q <= '0;
            tx_q      <= cur_bit;
            state_q   <= DATA;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        DATA: begin
          if (slot_end) begin
            div_q <= '0;
            // the counter stops at DATA_W-1 so it never wraps its clog2 width
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shreg_q   <= shreg_d;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              tx_q      <= next_bit;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        STOP: begin
          if (slot_end) begin
            div_q   <= '0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.state = state_q;
  assign LED0      = tx_q;
  assign LED9      = busy_q;
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (8/4/LSB-first and 8/1/MSB-first) driven one at a time;
// a per-cycle expected line queue is filled on each accepted load and drained by a negedge monitor.
module tb_serial_tx;
  logic clock;
  logic resetn;
  logic led0_a, led9_a, led0_b, led9_b;

  serial_tx_if #(.DATA_W(8)) bus_a ();
  serial_tx_if #(.DATA_W(8)) bus_b ();

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .LSB_FIRST(1)) dut_a (
    .clock(clock), .resetn(resetn), .bus(bus_a), .LED0(led0_a), .LED9(led9_a)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .LSB_FIRST(0)) dut_b (
    .clock(clock), .resetn(resetn), .bus(bus_b), .LED0(led0_b), .LED9(led9_b)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [0:0] exp_q[$];
  logic       done_due[2];
  int         active_id;
  int         n_checks;
  int         n_fail;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, id, act, exp, $time);
    end
  endtask

  // reference frame: start slot, data slots in configured order, stop slot
  task automatic push_frame(input int id, input logic [7:0] d);
    int   cpb;
    logic b;
    cpb = (id == 0) ? 4 : 1;
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b = (id == 0) ? d[i] : d[7-i];
      for (int c = 0; c < cpb; c++) exp_q.push_back(b);
    end
    for (int c = 0; c < cpb; c++) exp_q.push_back(1'b1);
  endtask

  task automatic flush_model();
    exp_q.delete();
    done_due[0] = 1'b0;
    done_due[1] = 1'b0;
  endtask

  // monitor
  task automatic mon(input int id, input logic t, input logic r, input logic b, input logic dn,
                     input logic l0, input logic l9);
    logic e;
    if (!resetn) begin
      chk("rst_tx", id, t, 1'b1);
      chk("rst_ready", id, r, 1'b1);
      chk("rst_busy", id, b, 1'b0);
      chk("rst_done", id, dn, 1'b0);
      done_due[id] = 1'b0;
    end else if (id == active_id && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("tx", id, t, e);
      chk("led0", id, l0, e);
      chk("busy", id, b, 1'b1);
      chk("led9", id, l9, 1'b1);
      chk("ready", id, r, 1'b0);
      chk("done_early", id, dn, 1'b0);
      if (exp_q.size() == 0) done_due[id] = 1'b1;
    end else begin
      chk("idle_tx", id, t, 1'b1);
      chk("idle_led0", id, l0, 1'b1);
      chk("idle_busy", id, b, 1'b0);
      chk("idle_led9", id, l9, 1'b0);
      chk("idle_ready", id, r, 1'b1);
      chk("done", id, dn, done_due[id]);
      done_due[id] = 1'b0;
    end
  endtask

  always @(negedge clock) begin
    mon(0, bus_a.tx, bus_a.ready, bus_a.busy, bus_a.done, led0_a, led9_a);
    mon(1, bus_b.tx, bus_b.ready, bus_b.busy, bus_b.done, led0_b, led9_b);
  end

  // driver tasks: all start and end 1 time unit after a rising edge
  task automatic set_load(input int id, input logic v);
    if (id == 0) bus_a.load = v;
    else         bus_b.load = v;
  endtask

  task automatic set_data(input int id, input logic [7:0] v);
    if (id == 0) bus_a.data_in = v;
    else         bus_b.data_in = v;
  endtask

  task automatic send(input int id, input logic [7:0] d);
    active_id = id;
    set_data(id, d);
    set_load(id, 1'b1);
    @(posedge clock);
    push_frame(id, d);
    #1;
    set_load(id, 1'b0);
    set_data(id, 8'($urandom));
  endtask

  // load pulse while busy, with data_in churning every cycle until then
  task automatic ignore_pulse(input int id, input int off);
    for (int i = 1; i < off; i++) begin
      @(posedge clock);
      #1 set_data(id, 8'($urandom));
    end
    set_load(id, 1'b1);
    set_data(id, 8'h3C);
    @(posedge clock);
    #1 set_load(id, 1'b0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clock);
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clock);
      n++;
    end
    chk("drain_timeout", active_id, 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int          id;
    logic [7:0]  d;
    n_checks  = 0;
    n_fail    = 0;
    active_id = 0;
    flush_model();
    resetn        = 1'b0;
    bus_a.load    = 1'b0;
    bus_b.load    = 1'b0;
    bus_a.data_in = 8'h00;
    bus_b.data_in = 8'h00;

    // reset held 3 cycles, released between edges
    repeat (3) @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock);
    #1;
    idle_cycles(2);

    // 0xA5, LSB first, 4 clocks per bit, with an ignored load and data churn mid-frame
    send(0, 8'hA5);
    ignore_pulse(0, 14);
    wait_idle();
    idle_cycles(3);

    // 0x81, MSB first, 1 clock per bit
    send(1, 8'h81);
    wait_idle();
    idle_cycles(3);

    // back-to-back: load held high, second frame accepted in the done cycle
    active_id = 0;
    set_data(0, 8'h00);
    set_load(0, 1'b1);
    @(posedge clock);
    push_frame(0, 8'h00);
    #1 set_data(0, 8'hFF);
    repeat (40) @(posedge clock);
    @(posedge clock);
    push_frame(0, 8'hFF);
    #1 set_load(0, 1'b0);
    wait_idle();
    idle_cycles(3);

    // asynchronous reset between edges during the start bit
    send(0, 8'h66);
    #1 resetn = 1'b0;
    flush_model();
    #1;
    chk("async_rst_tx", 0, bus_a.tx, 1'b1);
    chk("async_rst_busy", 0, bus_a.busy, 1'b0);
    chk("async_rst_ready", 0, bus_a.ready, 1'b1);
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
    @(posedge clock);
    #1;
    idle_cycles(2);

    // reset during data bit 3, then a clean frame
    send(0, 8'hC3);
    repeat (17) @(posedge clock);
    #1 resetn = 1'b0;
    flush_model();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    idle_cycles(3);
    send(0, 8'h5A);
    wait_idle();
    idle_cycles(3);

    // randomized frames on both instances
    for (int k = 0; k < 24; k++) begin
      id = $urandom_range(0, 1);
      d  = 8'($urandom);
      send(id, d);
      if ($urandom_range(0, 1) == 1) ignore_pulse(id, $urandom_range(1, (id == 0) ? 39 : 9));
      wait_idle();
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(5);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
